// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit for the in-order RV32I core.
// Per-register writer age/producer stage drives decode stall and operand bypass selection.
module hazard_scoreboard #(
  parameter int PIPE_DEPTH = 4,
  parameter int NREGS      = 32,
  parameter int FWD_EN     = 1,
  parameter int ALU_STAGE  = 2,
  parameter int LOAD_STAGE = 3,
  localparam int SW        = $clog2(PIPE_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          freeze,
  input  logic          flush,
  input  logic          flush_all,
  input  logic          id_valid,
  input  logic [4:0]    id_rs1,
  input  logic          id_rs1_used,
  input  logic [4:0]    id_rs2,
  input  logic          id_rs2_used,
  input  logic [4:0]    id_rd,
  input  logic          id_rd_we,
  input  logic          id_is_load,
  output logic          stall,
  output logic          issue,
  output logic          fwd1_en,
  output logic [SW-1:0] fwd1_stage,
  output logic          fwd2_en,
  output logic [SW-1:0] fwd2_stage
);

  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(PIPE_DEPTH);
  localparam logic [SW-1:0] ALU_S   = SW'(ALU_STAGE);
  localparam logic [SW-1:0] LOAD_S  = SW'(LOAD_STAGE);
  localparam logic [SW-1:0] FIRST_S = SW'(2);

  // Handshake: the decode instruction transfers on a cycle where id_valid && issue;
  // stall is the not-ready indication and holds fetch/decode while a bubble is injected.

  // age: 0 = no writer in flight, else stage currently holding the newest writer.
  // prod: stage at whose end that writer's result exists (valid only while age != 0).
  logic [SW-1:0] age  [NREGS];
  logic [SW-1:0] prod [NREGS];

  logic [4:0]    src      [2];
  logic          src_used [2];
  logic [RW-1:0] src_idx  [2];
  logic [SW-1:0] src_age  [2];
  logic [SW-1:0] src_prod [2];
  logic          haz      [2];
  logic          fen      [2];
  logic [SW-1:0] fst      [2];

  logic [RW-1:0] rd_idx;
  logic          rd_track;

  always_comb begin
    src[0]      = id_rs1;
    src[1]      = id_rs2;
    src_used[0] = id_rs1_used;
    src_used[1] = id_rs2_used;
    for (int i = 0; i < 2; i++) begin
      src_idx[i]  = src[i][RW-1:0];
      src_age[i]  = '0;
      src_prod[i] = '0;
      haz[i]      = 1'b0;
      fen[i]      = 1'b0;
      fst[i]      = '0;
      if (src_used[i] && (src[i] != 5'd0) && (int'(src[i]) < NREGS)) begin
        src_age[i]  = age[src_idx[i]];
        src_prod[i] = prod[src_idx[i]];
      end
      if (src_age[i] != '0) begin
        if (FWD_EN != 0) begin
          // A result produced at the end of this cycle can still be muxed in,
          // so only a writer strictly before its producer stage blocks.
          if (src_age[i] < src_prod[i]) begin
            haz[i] = 1'b1;
          end else if (src_age[i] != DEPTH_S) begin
            fen[i] = 1'b1;
            fst[i] = src_age[i];
          end
        end else if (src_age[i] < DEPTH_S) begin
          haz[i] = 1'b1;
        end
      end
    end
  end

  assign stall      = id_valid & ~flush & (haz[0] | haz[1]);
  assign issue      = id_valid & ~stall & ~flush & ~freeze;
  assign fwd1_en    = fen[0];
  assign fwd1_stage = fst[0];
  assign fwd2_en    = fen[1];
  assign fwd2_stage = fst[1];

  assign rd_idx   = id_rd[RW-1:0];
  assign rd_track = issue & id_rd_we & (id_rd != 5'd0) & (int'(id_rd) < NREGS);

  always_ff @(posedge clk) begin
    if (reset || flush_all) begin
      for (int r = 0; r < NREGS; r++) age[r] <= '0;
    end else if (!freeze) begin
      for (int r = 0; r < NREGS; r++) begin
        if (age[r] == DEPTH_S)  age[r] <= '0;
        else if (age[r] != '0)  age[r] <= age[r] + SW'(1);
      end
      // Newest writer wins: a re-issued rd discards the older in-flight entry.
      if (rd_track) age[rd_idx] <= FIRST_S;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush_all && !freeze && rd_track)
      prod[rd_idx] <= id_is_load ? LOAD_S : ALU_S;
  end

endmodule
